// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: serves 32-bit CPU fetches from a byte-wide
// external memory, assembling four bytes big-endian into a one-entry word
// buffer. Hits on the buffered word return combinationally with no stall.
//
// Memory handshake: mem_rd_o acts as "valid" for the request and holds
// mem_addr_o stable until the memory answers; a byte transfers at the rising
// edge where mem_rd_o and mem_ready_i are both high, and mem_data_i is only
// looked at in that cycle.
module inst_fetch_responder #(
  parameter int MEM_AW  = 17,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  input  logic              flush_i,
  output logic [31:0]       inst_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic              mem_rd_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  input  logic              mem_ready_i,
  output logic              dbg_state_o
);

  localparam int WAW = MEM_AW - 2;
  // Last wait count before giving up on a byte.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            buf_valid_q, buf_valid_d;
  logic [WAW-1:0]  tag_q, tag_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic [WAW-1:0]  fill_addr_q, fill_addr_d;
  logic [1:0]      k_q, k_d;
  logic [7:0]      wait_q, wait_d;
  logic [31:0]     asm_q, asm_d;
  logic            discard_q, discard_d;
  logic            err_q, err_d;

  logic [WAW-1:0]  word_addr;
  logic            hit;
  logic [31:0]     merged;
  logic            unused_addr_bits;

  assign word_addr        = addr_i[MEM_AW-1:2];
  assign unused_addr_bits = ^{addr_i[31:MEM_AW], addr_i[1:0]};
  assign hit              = ce_i & buf_valid_q & (word_addr == tag_q);

  // CPU side is purely combinational; the rst term keeps stall low while
  // reset is held even if the CPU is already asserting ce_i.
  assign inst_o      = hit ? buf_data_q : 32'h0;
  assign stall_req_o = rst & ce_i & ~hit;
  assign err_o       = err_q;
  assign mem_rd_o    = (state_q == S_READ);
  assign mem_addr_o  = mem_rd_o ? {fill_addr_q, k_q} : '0;
  assign dbg_state_o = state_q;

  // Partial word with the incoming byte placed at lane k (k=0 is the MSB).
  always_comb begin
    merged = asm_q;
    case (k_q)
      2'd0:    merged[31:24] = mem_data_i;
      2'd1:    merged[23:16] = mem_data_i;
      2'd2:    merged[15:8]  = mem_data_i;
      default: merged[7:0]   = mem_data_i;
    endcase
  end

  // Next-state logic: miss detection in IDLE, byte collection and timeout in READ.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    tag_d       = tag_q;
    buf_data_d  = buf_data_q;
    fill_addr_d = fill_addr_q;
    k_d         = k_q;
    wait_d      = wait_q;
    asm_d       = asm_q;
    discard_d   = discard_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush_i) buf_valid_d = 1'b0;
        if (ce_i && !hit) begin
          fill_addr_d = word_addr;
          k_d         = 2'd0;
          wait_d      = 8'd0;
          discard_d   = 1'b0;
          state_d     = S_READ;
        end
      end
      default: begin
        // A flush during a fill also drops the stale buffer right away and
        // makes sure the word being fetched is not marked valid at the end.
        if (flush_i) begin
          discard_d   = 1'b1;
          buf_valid_d = 1'b0;
        end
        if (mem_ready_i) begin
          asm_d  = merged;
          k_d    = k_q + 2'd1;
          wait_d = 8'd0;
          if (k_q == 2'd3) begin
            tag_d       = fill_addr_q;
            buf_data_d  = merged;
            buf_valid_d = ~(discard_q | flush_i);
            discard_d   = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d       = 1'b1;
          buf_valid_d = 1'b0;
          discard_d   = 1'b0;
          wait_d      = 8'd0;
          k_d         = 2'd0;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      buf_valid_q <= 1'b0;
      tag_q       <= '0;
      buf_data_q  <= 32'h0;
      fill_addr_q <= '0;
      k_q         <= 2'd0;
      wait_q      <= 8'd0;
      asm_q       <= 32'h0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      tag_q       <= tag_d;
      buf_data_q  <= buf_data_d;
      fill_addr_q <= fill_addr_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      asm_q       <= asm_d;
      discard_q   <= discard_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Bench for inst_fetch_responder: byte memory model with programmable wait
// states, scoreboard queues for expected instruction words and byte addresses.
module tb_inst_fetch_responder;

  localparam int MEM_AW = 17;

  logic              clk;
  logic              rst;
  logic              ce_i;
  logic [31:0]       addr_i;
  logic              flush_i;
  logic [31:0]       inst_o;
  logic              stall_req_o;
  logic              err_o;
  logic              mem_rd_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;
  logic              mem_ready_i;
  logic              dbg_state_o;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  mem [0:255];

  int total;
  int bad;
  int wait_cfg;
  bit stuck;
  int wcnt;
  int stall_cnt;

  inst_fetch_responder #(.MEM_AW(MEM_AW), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .addr_i      (addr_i),
    .flush_i     (flush_i),
    .inst_o      (inst_o),
    .stall_req_o (stall_req_o),
    .err_o       (err_o),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .mem_ready_i (mem_ready_i),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
  endfunction

  // ---------------- memory model ----------------
  // Wait counter advances on each rising edge spent in a request.
  always @(posedge clk) begin
    if (!rst)                         wcnt = 0;
    else if (mem_rd_o && mem_ready_i) wcnt = 0;
    else if (mem_rd_o)                wcnt = wcnt + 1;
    else                              wcnt = 0;
  end

  // Drives ready/data mid-cycle and scores every byte transfer address.
  always @(negedge clk) begin
    if (mem_rd_o && !stuck && wcnt >= wait_cfg) begin
      mem_ready_i = 1'b1;
      mem_data_i  = mem[mem_addr_o[7:0]];
    end else begin
      mem_ready_i = 1'b0;
      mem_data_i  = 8'h00;
    end
    if (mem_rd_o && mem_ready_i) begin
      if (exp_addr_q.size() == 0) check_eq("rd_extra", 32'(exp_addr_q.size()), 32'd1);
      else                        check_eq("rd_addr", 32'(mem_addr_o), exp_addr_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fill(input logic [31:0] a);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back((a & 32'h1FFFC) + 32'(i));
  endtask

  task automatic step();
    @(negedge clk);
    if (stall_req_o) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_hit(input string tag, input int exp_stall);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!stall_req_o) begin
        if (exp_q.size() == 0) check_eq({tag, "_noexp"}, 32'(exp_q.size()), 32'd1);
        else                   check_eq({tag, "_inst"}, inst_o, exp_q.pop_front());
        check_eq({tag, "_rd"}, 32'(mem_rd_o), 32'd0);
        done = 1'b1;
      end else begin
        stall_cnt++;
      end
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_stall, input string tag);
    exp_q.push_back(word_at(a));
    if (exp_stall > 0) push_fill(a);
    ce_i      = 1'b1;
    addr_i    = a;
    stall_cnt = 0;
    run_until_hit(tag, exp_stall);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int errs;
    int err_cyc;
    int rd_cnt;
    total    = 0;
    bad      = 0;
    wait_cfg = 0;
    stuck    = 1'b0;
    wcnt     = 0;
    rst      = 1'b0;
    ce_i     = 1'b1;
    addr_i   = 32'h0;
    flush_i  = 1'b0;
    mem_ready_i = 1'b0;
    mem_data_i  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h34; mem[1] = 8'h02; mem[2] = 8'h00; mem[3] = 8'h01;

    // Reset state, with the CPU already requesting a fetch.
    #12;
    check_eq("rst_inst", inst_o, 32'h0);
    check_eq("rst_stall", 32'(stall_req_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_rd", 32'(mem_rd_o), 32'd0);
    check_eq("rst_maddr", 32'(mem_addr_o), 32'd0);
    ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic fill and refetch hits.
    fetch(32'h0, 5, "fill0");
    check_eq("word0_const", word_at(32'h0), 32'h34020001);
    fetch(32'h0, 0, "hit0");
    fetch(32'h2, 0, "hit2");

    // Back-to-back misses; the buffer ends up holding word 0x8.
    fetch(32'h4, 5, "fill4");
    fetch(32'h8, 5, "fill8");
    fetch(32'h8, 0, "hit8");
    fetch(32'h4, 5, "refill4");

    // Three wait cycles per byte.
    wait_cfg = 3;
    fetch(32'hC, 17, "wait3");
    wait_cfg = 0;

    // Address changes during byte 1 of a fill.
    exp_q.push_back(word_at(32'h20));
    push_fill(32'h10);
    push_fill(32'h20);
    ce_i = 1'b1;
    addr_i = 32'h10;
    stall_cnt = 0;
    step();
    step();
    addr_i = 32'h20;
    run_until_hit("addr_chg", 10);

    // Flush during a fill: the fill completes but is discarded, then refills.
    exp_q.push_back(word_at(32'h0));
    push_fill(32'h0);
    push_fill(32'h0);
    addr_i = 32'h0;
    stall_cnt = 0;
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    run_until_hit("flush_fill", 10);

    // Flush on a hit still returns data that cycle; the next cycle misses.
    flush_i = 1'b1;
    @(negedge clk);
    check_eq("flush_hit_inst", inst_o, word_at(32'h0));
    check_eq("flush_hit_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    fetch(32'h0, 5, "flush_idle");

    // ce_i low: outputs quiet even though the buffer holds the address.
    ce_i = 1'b0;
    @(negedge clk);
    check_eq("ce0_inst", inst_o, 32'h0);
    check_eq("ce0_stall", 32'(stall_req_o), 32'd0);
    @(posedge clk);
    #1;

    // Memory never answers: timeout after 8 waits, then retry from byte 0.
    stuck = 1'b1;
    ce_i = 1'b1;
    addr_i = 32'h40;
    errs = 0;
    err_cyc = -1;
    rd_cnt = 0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (err_o) begin
        errs++;
        err_cyc = c;
        check_eq("to_err_rd", 32'(mem_rd_o), 32'd0);
      end
      if (mem_rd_o) rd_cnt++;
      if (c == 10) begin
        check_eq("to_retry_rd", 32'(mem_rd_o), 32'd1);
        check_eq("to_retry_addr", 32'(mem_addr_o), 32'h40);
      end
      if (c < 12) begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("to_err_count", 32'(errs), 32'd1);
    check_eq("to_err_cycle", 32'(err_cyc), 32'd9);
    check_eq("to_rd_cycles", 32'(rd_cnt), 32'd11);

    // Asynchronous reset in the middle of the retry fill.
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_rd", 32'(mem_rd_o), 32'd0);
    check_eq("arst_maddr", 32'(mem_addr_o), 32'd0);
    check_eq("arst_stall", 32'(stall_req_o), 32'd0);
    check_eq("arst_inst", inst_o, 32'h0);
    check_eq("arst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    stuck = 1'b0;
    ce_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Buffer contents were lost in reset.
    fetch(32'h0, 5, "post_rst");

    ce_i = 1'b0;
    repeat (3) @(posedge clk);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Responder side of the CPU instruction-fetch interface: ce, word address in, 32-bit instruction out, plus a stall request.
- Serves fetches from a slow byte-wide external instruction memory that uses a ready handshake.
- Assembles four bytes per word, big-endian, and keeps a one-entry word buffer so repeated fetches of the same word return immediately.
- Sits between the openmips core fetch port and the off-chip or boot memory; it replaces a combinational ROM when memory latency is non-zero.

Parameters:
- MEM_AW, 17, byte-address width of the external memory.
- TIMEOUT, 255, maximum cycles to wait for mem_ready_i on one byte before aborting (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce_i  in  1  fetch enable from CPU.
- addr_i  in  32  CPU instruction byte address; bits [1:0] ignored.
- flush_i  in  1  invalidate the word buffer.
- inst_o  out  32  instruction to CPU.
- stall_req_o  out  1  CPU must hold its PC while high.
- err_o  out  1  one-cycle pulse on memory timeout.
- mem_rd_o  out  1  external byte read request.
- mem_addr_o  out  MEM_AW  external byte address.
- mem_data_i  in  8  external read data, valid when mem_ready_i=1.
- mem_ready_i  in  1  external read completion.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - state to IDLE, buf_valid to 0, tag, buf_data and byte counter to 0.
  - inst_o=0, stall_req_o=0, err_o=0, mem_rd_o=0, mem_addr_o=0.
- Hit: ce_i=1, buf_valid=1 and addr_i[MEM_AW-1:2]==tag.
  - inst_o=buf_data and stall_req_o=0, both combinational in the same cycle.
- ce_i=0: inst_o=0, stall_req_o=0, in any state.
- Miss in IDLE (ce_i=1 and not a hit):
  - stall_req_o=1 combinationally.
  - Latch word address addr_i[MEM_AW-1:2] into fill_addr; clear byte counter k; next state READ.
- READ:
  - mem_rd_o=1, mem_addr_o={fill_addr,k[1:0]}.
  - On mem_ready_i=1: store mem_data_i into byte k, with k=0 in bits [31:24] and k=3 in bits [7:0]; k increments; the wait counter clears.
  - When the fourth byte is accepted: write tag=fill_addr and buf_data, set buf_valid=1 unless the discard flag is set, clear discard, go IDLE. mem_rd_o=0 in IDLE.
- Latency with mem_ready_i held high:
  - Miss cycle 0 (IDLE), then bytes captured at the ends of cycles 1-4.
  - Cycle 5 is a hit: stall_req_o is high for exactly 5 cycles.
  - Each memory wait cycle adds 1.
- stall_req_o=1 whenever ce_i=1 and no hit, including during READ.
- Address change mid-fill: the current fill completes unaltered. The new address then misses in IDLE and starts a new fill.
- ce_i dropping mid-fill: the fill still completes and the buffer is updated. Memory transactions are never abandoned except on timeout.
- flush_i:
  - In IDLE: buf_valid=0 from the next cycle.
  - In READ: sets discard, so the completing fill does not set buf_valid.
  - flush_i in the same cycle as the final byte also discards.
  - A flush in the same cycle as a hit still returns buffered data that cycle.
- Timeout:
  - The wait counter increments each READ cycle with mem_ready_i=0.
  - On reaching TIMEOUT: err_o=1 for one cycle, buf_valid=0, discard cleared, mem_rd_o=0, go IDLE.
  - If ce_i is still high, a new miss fill starts from byte 0 on the following cycle.
- Word addresses wrap modulo 2^(MEM_AW-2). The byte counter wraps 3 to 0 only at fill end.

Test Plan:
- Reset, then ce_i=1, addr_i=0x0, memory bytes 0x34,0x02,0x00,0x01, ready always 1:
  - stall_req_o high for 5 cycles, mem_addr_o steps 0,1,2,3.
  - Then inst_o=0x34020001, stall_req_o=0.
  - A refetch of 0x0 or 0x2 is a hit with no mem_rd_o.
- Fetch 0x4 then 0x8 back to back: each misses.
  - mem_addr_o 4..7 then 8..11; the buffer ends holding word 0x8.
  - A fetch of 0x4 afterwards misses again.
- Memory inserts 3 wait cycles per byte: stall_req_o high for 17 cycles; assembled word correct.
- addr_i changes from 0x10 to 0x20 during byte 1:
  - mem_addr_o completes 0x10..0x13, then starts 0x20.
  - inst_o=word@0x20 only after the second fill.
- flush_i pulsed during a fill of 0x0: the fill completes, and the next fetch of 0x0 misses and refills.
- mem_ready_i stuck 0 with TIMEOUT=8:
  - err_o pulses exactly once after 8 wait cycles, mem_rd_o drops for one cycle, then a retry begins at byte 0.
  - Reset asserted mid-fill clears all outputs immediately, without waiting for a clock edge.
